// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage ahead of ISA_decoder: local IMEM, one instruction per cycle,
// with decoder stalls, zero-bubble taken-branch redirects and the ap_done halt.
module instr_fetch_unit #(
    parameter int dwidth_inst = 32,
    parameter int IMEM_DEPTH  = 256,
    parameter int PC_W        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_wen,
    input  logic [PC_W-1:0]        prog_addr,
    input  logic [dwidth_inst-1:0] prog_data,
    input  logic                   start,
    input  logic                   is_not_vect,
    input  logic                   br_taken,
    input  logic [11:0]            branch_immediate,
    input  logic                   ap_done,
    output logic [dwidth_inst-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_W-1:0]        pc,
    output logic                   running,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PC_W-1:0]        r_pc;
    logic                   r_valid;
    logic [dwidth_inst-1:0] r_imem [IMEM_DEPTH];
    logic [dwidth_inst-1:0] r_rd_data;

    logic [PC_W-1:0]        w_rd_addr;
    logic [PC_W-1:0]        w_br_off;
    logic                   w_in_run;
    logic                   w_advance;
    logic                   w_halt;
    logic                   w_prog_ok;

    assign w_in_run  = (r_state == S_RUN);
    assign w_halt    = w_in_run && ap_done;
    assign w_advance = (r_state == S_FILL) || (w_in_run && !ap_done);
    assign w_prog_ok = (r_state == S_IDLE) || (r_state == S_DONE);

    // Word offset: byte bits [1:0] are dropped; the cast sign-extends or wraps to PC_W.
    assign w_br_off = PC_W'($signed(branch_immediate[11:2]));

    always_comb begin
        w_rd_addr = '0;
        if (r_state == S_RUN) begin
            if (!is_not_vect) begin
                w_rd_addr = r_pc;
            end else if (br_taken) begin
                w_rd_addr = r_pc + w_br_off;
            end else begin
                w_rd_addr = r_pc + PC_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)   w_state_next = S_FILL;
            S_FILL:               w_state_next = S_RUN;
            S_RUN:   if (ap_done) w_state_next = S_DONE;
            S_DONE:  if (start)   w_state_next = S_FILL;
            default:              w_state_next = S_IDLE;
        endcase
    end

    // Writes are only accepted while idle, so they never collide with a fetch read.
    always_ff @(posedge clk) begin
        if (prog_wen && w_prog_ok) begin
            r_imem[prog_addr] <= prog_data;
        end
        if (w_advance) begin
            r_rd_data <= r_imem[w_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_advance) begin
                r_pc    <= w_rd_addr;
                r_valid <= 1'b1;
            end else if (w_halt) begin
                r_valid <= 1'b0;
            end
        end
    end

    // The RAM output register has no reset; the valid flag masks it to zero instead.
    assign instr       = r_valid ? r_rd_data : '0;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign running     = (r_state == S_FILL) || (r_state == S_RUN);
    assign done        = (r_state == S_DONE);

endmodule
